uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser_pkg.sv | 19 +
 rtl/uart_frame_parser_frame_buf.sv | 27 ++
 rtl/uart_frame_parser.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared types and defaults for the UART frame parser.
// Optional inter-byte timeout is enabled with UART_FRAME_TIMEOUT_EN.
package uart_frame_parser_pkg;

  localparam int          BIT_PERIOD  = 868;
  localparam int          FRAME_MAX   = 16;
  localparam logic [7:0]  FRAME_SOF   = 8'hAA;
  localparam int          FRAME_TMO   = 20 * BIT_PERIOD;

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHECK   = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

endpackage

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload byte store: one write port, registered read port.
// Contents are not reset; only the read register is.
module uart_frame_parser_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SOF, CMD, LEN, payload, XOR checksum; drains good payloads.
// Define UART_FRAME_TIMEOUT_EN to enable the inter-byte timeout.
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter int         MAX_LEN        = FRAME_MAX,
  parameter logic [7:0] SOF_BYTE       = FRAME_SOF,
  parameter int         TIMEOUT_CYCLES = FRAME_TMO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic [7:0] out_cmd,
  output logic [7:0] out_len,
  output logic       frame_ok,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err_checksum,
  output logic       err_len,
  output logic       err_overrun,
  output logic       err_timeout,
  output logic       busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t          state;
  logic [7:0]      cmd_sh;
  logic [7:0]      len_sh;
  logic [7:0]      xsum;
  logic [IW-1:0]   widx;
  logic [IW-1:0]   ridx;
  logic [IW-1:0]   raddr;
  logic            we;
  logic            xfer;

  assign busy = (state != S_HUNT);
  assign we   = (state == S_PAYLOAD) && rx_done;
  assign xfer = out_valid && out_ready;

  // Read one address ahead so the registered read lands with the transfer.
  assign raddr = (state != S_DRAIN) ? '0 :
                 xfer ? ridx + IW'(1) : ridx;

  uart_frame_parser_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (widx),
    .wdata (rx_data),
    .raddr (raddr),
    .rdata (out_data)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        tmo;

  assign tmo = (tcnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || rx_done || state == S_HUNT || state == S_DRAIN)
      tcnt <= '0;
    else
      tcnt <= tcnt + 32'd1;
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^32'(TIMEOUT_CYCLES);
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_HUNT;
      cmd_sh       <= '0;
      len_sh       <= '0;
      xsum         <= '0;
      widx         <= '0;
      ridx         <= '0;
      out_cmd      <= '0;
      out_len      <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      frame_ok     <= 1'b0;
      err_checksum <= 1'b0;
      err_len      <= 1'b0;
      err_overrun  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
    end else begin
      frame_ok     <= 1'b0;
      err_checksum <= 1'b0;
      err_len      <= 1'b0;
      err_overrun  <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
      err_timeout  <= 1'b0;
`endif
      unique case (state)
        S_HUNT: begin
          if (rx_done && rx_data == SOF_BYTE) state <= S_CMD;
        end
        S_CMD: begin
          if (rx_done) begin
            cmd_sh <= rx_data;
            xsum   <= rx_data;
            state  <= S_LEN;
          end
        end
        S_LEN: begin
          if (rx_done) begin
            len_sh <= rx_data;
            xsum   <= xsum ^ rx_data;
            if (rx_data > 8'(MAX_LEN)) begin
              err_len <= 1'b1;
              state   <= S_HUNT;
            end else if (rx_data == 8'd0) begin
              state <= S_CHECK;
            end else begin
              widx  <= '0;
              state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_done) begin
            xsum <= xsum ^ rx_data;
            widx <= widx + IW'(1);
            if (8'(widx) == len_sh - 8'd1) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (rx_done) begin
            if (rx_data != xsum) begin
              err_checksum <= 1'b1;
              state        <= S_HUNT;
            end else begin
              out_cmd  <= cmd_sh;
              out_len  <= len_sh;
              frame_ok <= 1'b1;
              ridx     <= '0;
              if (len_sh == 8'd0) begin
                state <= S_HUNT;
              end else begin
                out_valid <= 1'b1;
                out_last  <= (len_sh == 8'd1);
                state     <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (rx_done) err_overrun <= 1'b1;
          if (xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_HUNT;
            end else begin
              ridx     <= ridx + IW'(1);
              out_last <= (8'(ridx) + 8'd2 == len_sh);
            end
          end
        end
        default: state <= S_HUNT;
      endcase
`ifdef UART_FRAME_TIMEOUT_EN
      // A byte arriving on the deadline cycle wins over the timeout.
      if (busy && state != S_DRAIN && !rx_done && tmo) begin
        err_timeout <= 1'b1;
        state       <= S_HUNT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with hand-computed expectations.
// Timeout case is exercised only when UART_FRAME_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_frame_parser;
  import uart_frame_parser_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_cmd, out_len, out_data;
  logic       frame_ok, out_valid, out_last;
  logic       err_checksum, err_len, err_overrun, err_timeout, busy;

  always #5 clk = ~clk;

  uart_frame_parser dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .out_cmd      (out_cmd),
    .out_len      (out_len),
    .frame_ok     (frame_ok),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .err_checksum (err_checksum),
    .err_len      (err_len),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_ok = 0, n_ec = 0, n_el = 0, n_eo = 0, n_et = 0;
  int b_ok, b_ec, b_el, b_eo, b_et, b_q;
  logic [7:0] q_data [$];
  logic       q_last [$];
  logic [7:0] fr [$];

  always @(posedge clk) begin
    if (frame_ok)     n_ok++;
    if (err_checksum) n_ec++;
    if (err_len)      n_el++;
    if (err_overrun)  n_eo++;
    if (err_timeout)  n_et++;
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_last.push_back(out_last);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_ok = n_ok; b_ec = n_ec; b_el = n_el;
    b_eo = n_eo; b_et = n_et; b_q = q_data.size();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    rx_data = '0;
  endtask

  task automatic send_q(input logic [7:0] q [$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic wait_idle(input int limit);
    int k;
    step(2);
    for (k = 0; k < limit; k++) begin
      if (!busy && !out_valid) break;
      step(1);
    end
    chk("idle_reached", 32'(k < limit), 32'd1);
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_cmd", out_cmd, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    rst = 1'b0;
    step(1);

    // Good frame, consumer always ready
    out_ready = 1'b1;
    snap();
    fr = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(fr);
    chk("t1_busy_drain", busy, 1);
    wait_idle(40);
    chk("t1_ok", n_ok - b_ok, 1);
    chk("t1_cmd", out_cmd, 8'h01);
    chk("t1_len", out_len, 8'h02);
    chk("t1_cnt", q_data.size() - b_q, 2);
    chk("t1_d0", q_data[b_q], 8'h10);
    chk("t1_d1", q_data[b_q+1], 8'h20);
    chk("t1_l0", q_last[b_q], 0);
    chk("t1_l1", q_last[b_q+1], 1);
    chk("t1_errs", (n_ec-b_ec)+(n_el-b_el)+(n_eo-b_eo), 0);
    chk("t1_busy", busy, 0);

    // Backpressure holds the first byte stable
    out_ready = 1'b0;
    snap();
    send_q(fr);
    chk("t2_valid", out_valid, 1);
    chk("t2_data0", out_data, 8'h10);
    chk("t2_last0", out_last, 0);
    step(5);
    chk("t2_hold_valid", out_valid, 1);
    chk("t2_hold_data", out_data, 8'h10);
    out_ready = 1'b1;
    wait_idle(40);
    chk("t2_cnt", q_data.size() - b_q, 2);
    chk("t2_d0", q_data[b_q], 8'h10);
    chk("t2_d1", q_data[b_q+1], 8'h20);
    chk("t2_l1", q_last[b_q+1], 1);

    // Bad checksum, then a good frame
    snap();
    fr = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h34};
    send_q(fr);
    wait_idle(40);
    chk("t3_ec", n_ec - b_ec, 1);
    chk("t3_ok", n_ok - b_ok, 0);
    chk("t3_cnt", q_data.size() - b_q, 0);
    snap();
    fr = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(fr);
    wait_idle(40);
    chk("t3_ok2", n_ok - b_ok, 1);
    chk("t3_cnt2", q_data.size() - b_q, 2);

    // LEN 17 is rejected
    snap();
    fr = '{8'hAA, 8'h05, 8'h11};
    send_q(fr);
    wait_idle(40);
    chk("t4_el", n_el - b_el, 1);
    chk("t4_ok", n_ok - b_ok, 0);

    // Zero-length frame
    snap();
    fr = '{8'hAA, 8'h07, 8'h00, 8'h07};
    send_q(fr);
    wait_idle(40);
    chk("t5_ok", n_ok - b_ok, 1);
    chk("t5_len", out_len, 8'h00);
    chk("t5_cmd", out_cmd, 8'h07);
    chk("t5_cnt", q_data.size() - b_q, 0);

    // One-byte payload: first byte is also last
    snap();
    fr = '{8'hAA, 8'h03, 8'h01, 8'h5A, 8'h58};
    send_q(fr);
    wait_idle(40);
    chk("t6_ok", n_ok - b_ok, 1);
    chk("t6_cnt", q_data.size() - b_q, 1);
    chk("t6_d0", q_data[b_q], 8'h5A);
    chk("t6_l0", q_last[b_q], 1);

    // Full 16-byte payload
    snap();
    begin
      logic [7:0] x;
      x = 8'h22 ^ 8'h10;
      fr = '{8'hAA, 8'h22, 8'h10};
      for (int i = 0; i < 16; i++) begin
        fr.push_back(8'(i * 3 + 1));
        x = x ^ 8'(i * 3 + 1);
      end
      fr.push_back(x);
    end
    send_q(fr);
    wait_idle(60);
    chk("t7_ok", n_ok - b_ok, 1);
    chk("t7_len", out_len, 8'h10);
    chk("t7_cnt", q_data.size() - b_q, 16);
    chk("t7_d15", q_data[b_q+15], 8'd46);
    chk("t7_l14", q_last[b_q+14], 0);
    chk("t7_l15", q_last[b_q+15], 1);

    // Garbage before a good frame
    snap();
    fr = '{8'h55, 8'hFF, 8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(fr);
    wait_idle(40);
    chk("t8_ok", n_ok - b_ok, 1);
    chk("t8_errs", (n_ec-b_ec)+(n_el-b_el)+(n_eo-b_eo), 0);
    chk("t8_cnt", q_data.size() - b_q, 2);

    // SOF during DRAIN is an overrun and starts nothing
    out_ready = 1'b0;
    snap();
    fr = '{8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33};
    send_q(fr);
    send_byte(8'hAA);
    out_ready = 1'b1;
    wait_idle(40);
    fr = '{8'h01, 8'h00, 8'h01};
    send_q(fr);
    wait_idle(40);
    chk("t9_eo", n_eo - b_eo, 1);
    chk("t9_ok", n_ok - b_ok, 1);
    chk("t9_busy", busy, 0);
    chk("t9_cnt", q_data.size() - b_q, 2);

    // Reset mid-frame discards the partial frame
    snap();
    fr = '{8'hAA, 8'h01};
    send_q(fr);
    chk("t10_busy_pre", busy, 1);
    rst = 1'b1;
    step(1);
    chk("t10_busy_rst", busy, 0);
    chk("t10_valid_rst", out_valid, 0);
    rst = 1'b0;
    fr = '{8'h02, 8'h10, 8'h20, 8'h33};
    send_q(fr);
    wait_idle(40);
    chk("t10_ok", n_ok - b_ok, 0);
    chk("t10_ec", n_ec - b_ec, 0);

`ifdef UART_FRAME_TIMEOUT_EN
    // Silence after a partial frame times out
    snap();
    fr = '{8'hAA, 8'h01};
    send_q(fr);
    chk("t11_busy_pre", busy, 1);
    wait_idle(FRAME_TMO + 20);
    chk("t11_et", n_et - b_et, 1);
    chk("t11_busy", busy, 0);
`else
    chk("t11_et_tied", err_timeout, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
